// File: rtl/set_bit_enumerator_pkg.sv
// Shared definitions for the set-bit enumerator and its bitmap-counting siblings:
// FSM encoding plus the index/count width derivation used by the popcount tree.
package set_bit_enumerator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of a bit index into an n-bit vector (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a count over an n-bit vector; one extra bit so the value n fits.
    function automatic int ord_width(input int n);
        return idx_width(n) + 1;
    endfunction

endpackage

// File: rtl/set_bit_enumerator_lsb_index.sv
// Lowest-set-bit priority encoder: returns the position of the least significant
// set bit of i_vec, or 0 when no bit is set. Purely combinational.
module lsb_index
    import set_bit_enumerator_pkg::*;
#(
    parameter int IN_SIZE  = 16,
    parameter int IDX_SIZE = idx_width(IN_SIZE)
) (
    input  logic [IN_SIZE-1:0]  i_vec,
    output logic [IDX_SIZE-1:0] o_index
);

    logic [IN_SIZE-1:0] w_onehot;

    // Two's-complement trick isolates the lowest set bit as a one-hot word.
    assign w_onehot = i_vec & (~i_vec + IN_SIZE'(1));

    // Each index bit is the OR of the one-hot positions whose index has that bit set.
    genvar gi;
    generate
        for (gi = 0; gi < IDX_SIZE; gi++) begin : g_idx_bit
            logic w_bit;
            always_comb begin
                w_bit = 1'b0;
                for (int i = 0; i < IN_SIZE; i++) begin
                    if (((i >> gi) & 1) == 1) begin
                        w_bit = w_bit | w_onehot[i];
                    end
                end
            end
            assign o_index[gi] = w_bit;
        end
    endgenerate

endmodule

// File: rtl/set_bit_enumerator.sv
// Serialises the set-bit positions of an accepted vector, lowest first, one beat
// per cycle, with a running 1-based ordinal that ends at the vector's popcount.
module set_bit_enumerator
    import set_bit_enumerator_pkg::*;
#(
    parameter int IN_SIZE  = 16,
    parameter int IDX_SIZE = idx_width(IN_SIZE),
    parameter int OUT_SIZE = IDX_SIZE + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  A,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_SIZE-1:0] out_index,
    output logic [OUT_SIZE-1:0] out_ordinal,
    output logic                out_last,
    output logic                out_empty
);

    state_t              r_state;
    state_t              w_state_next;
    logic [IN_SIZE-1:0]  r_residue;
    logic [IN_SIZE-1:0]  w_residue_next;
    logic [OUT_SIZE-1:0] r_ordinal;
    logic [OUT_SIZE-1:0] w_ordinal_next;

    logic [IN_SIZE-1:0]  w_residue_clr;
    logic [IDX_SIZE-1:0] w_lsb;
    logic                w_emit;
    logic                w_last;
    logic                w_empty;
    logic                w_accept;
    logic                w_xfer;

    lsb_index #(
        .IN_SIZE  (IN_SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) u_lsb_index (
        .i_vec   (r_residue),
        .o_index (w_lsb)
    );

    assign w_residue_clr = r_residue & (r_residue - IN_SIZE'(1));
    assign w_emit        = (r_state == EMIT);
    assign w_last        = (w_residue_clr == '0);
    assign w_empty       = (r_residue == '0);

    // The out_ready term lets a new vector load on the final beat without a bubble.
    assign in_ready  = rst_n & (~w_emit | (w_last & out_ready));
    assign out_valid = rst_n & w_emit;

    assign out_index   = w_emit ? w_lsb : '0;
    assign out_ordinal = w_emit ? r_ordinal : '0;
    assign out_last    = w_emit & w_last;
    assign out_empty   = w_emit & w_empty;

    assign w_accept = in_valid & in_ready;
    assign w_xfer   = out_valid & out_ready;

    always_comb begin
        w_state_next   = r_state;
        w_residue_next = r_residue;
        w_ordinal_next = r_ordinal;
        if (w_accept) begin
            w_residue_next = A;
            w_ordinal_next = (A == '0) ? '0 : OUT_SIZE'(1);
            w_state_next   = EMIT;
        end else if (w_xfer) begin
            w_residue_next = w_residue_clr;
            w_ordinal_next = r_ordinal + OUT_SIZE'(1);
            if (w_last) begin
                w_state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_residue <= '0;
            r_ordinal <= '0;
        end else begin
            r_state   <= w_state_next;
            r_residue <= w_residue_next;
            r_ordinal <= w_ordinal_next;
        end
    end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Directed and randomized checks of set_bit_enumerator against a beat-list
// reference model built from each accepted vector.
module tb_set_bit_enumerator;

    localparam int IN_SIZE  = 16;
    localparam int IDX_SIZE = 4;
    localparam int OUT_SIZE = 5;

    typedef struct {
        int idx;
        int ord;
        bit last;
        bit empty;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [IN_SIZE-1:0]  A;
    logic                out_valid;
    logic                out_ready;
    logic [IDX_SIZE-1:0] out_index;
    logic [OUT_SIZE-1:0] out_ordinal;
    logic                out_last;
    logic                out_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IN_SIZE-1:0] vec_q[$];
    bit                 rdy_q[$];

    set_bit_enumerator #(
        .IN_SIZE  (IN_SIZE),
        .IDX_SIZE (IDX_SIZE),
        .OUT_SIZE (OUT_SIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_ordinal (out_ordinal),
        .out_last    (out_last),
        .out_empty   (out_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_index"},   32'(out_index),   32'd0);
        chk({tag, "_ordinal"}, 32'(out_ordinal), 32'd0);
        chk({tag, "_last"},    32'(out_last),    32'd0);
        chk({tag, "_empty"},   32'(out_empty),   32'd0);
    endtask

    // Streams every vector in vec_q through the DUT. Expected beats come from
    // listing the set positions of each accepted vector in ascending order.
    // mode 0: out_ready always 1; 1: random ready and random in_valid gaps;
    // 2: out_ready taken from rdy_q, then 1.
    task automatic run_stream(input string name, input int mode);
        beat_t q[$];
        int    cyc;
        bit    exp_valid;
        bit    exp_rdy;
        logic [IN_SIZE-1:0] a;
        int    k;
        int    r;
        cyc = 0;
        while ((vec_q.size() > 0 || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            in_valid = (vec_q.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            A = (vec_q.size() > 0) ? vec_q[0] : IN_SIZE'($urandom);
            case (mode)
                1:       out_ready = ($urandom_range(0, 9) < 7);
                2:       out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
                default: out_ready = 1'b1;
            endcase
            #1;
            exp_valid = (q.size() > 0);
            exp_rdy   = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk({name, "_out_valid"}, 32'(out_valid), 32'(exp_valid));
            chk({name, "_in_ready"},  32'(in_ready),  32'(exp_rdy));
            if (exp_valid) begin
                chk({name, "_index"},   32'(out_index),   32'(q[0].idx));
                chk({name, "_ordinal"}, 32'(out_ordinal), 32'(q[0].ord));
                chk({name, "_last"},    32'(out_last),    32'(q[0].last));
                chk({name, "_empty"},   32'(out_empty),   32'(q[0].empty));
            end
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                a = vec_q.pop_front();
                k = $countones(a);
                if (k == 0) begin
                    q.push_back(beat_t'{0, 0, 1'b1, 1'b1});
                end else begin
                    r = 0;
                    for (int i = 0; i < IN_SIZE; i++) begin
                        if (a[i]) begin
                            r++;
                            q.push_back(beat_t'{i, r, (r == k), 1'b0});
                        end
                    end
                end
            end
            cyc++;
        end
        chk({name, "_drained"}, 32'(q.size() + vec_q.size()), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_idle_ready"}, 32'(in_ready),  32'd1);
        $display("stream %s done: %0d cycles", name, cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_idle_outputs("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready",  32'(in_ready),  32'd1);
        chk("rst_rel_out_valid", 32'(out_valid), 32'd0);

        // Empty vector
        vec_q.push_back(16'h0000);
        run_stream("empty", 0);

        // Two distant bits
        vec_q.push_back(16'h8001);
        run_stream("ends", 0);

        // Full vector, ordinal reaches 16
        vec_q.push_back(16'hFFFF);
        run_stream("full", 0);

        // Stalls mid-vector; first ready entry covers the acceptance cycle
        vec_q.push_back(16'h0124);
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_stream("stall", 2);

        // Back-to-back with in_valid held
        vec_q.push_back(16'h0003);
        vec_q.push_back(16'h0010);
        run_stream("b2b", 0);

        // Reset mid-vector
        @(negedge clk);
        A = 16'h00F0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("mid_accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_beat1_valid", 32'(out_valid),   32'd1);
        chk("mid_beat1_index", 32'(out_index),   32'd4);
        chk("mid_beat1_ord",   32'(out_ordinal), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst2_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(in_ready),  32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);
        chk_idle_outputs("mid_rel");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mid_no_residual", 32'(out_valid), 32'd0);
        end
        vec_q.push_back(16'h0002);
        run_stream("post_rst", 0);

        // Randomized vectors of varying density, random back-pressure
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       vec_q.push_back(16'h0000);
                1:       vec_q.push_back(IN_SIZE'($urandom) & IN_SIZE'($urandom) & IN_SIZE'($urandom));
                2:       vec_q.push_back(IN_SIZE'($urandom) | IN_SIZE'($urandom));
                default: vec_q.push_back(IN_SIZE'($urandom));
            endcase
        end
        run_stream("random", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
